// File: rtl/audio_frame_writer_if.sv
// ---------------------------------------------------------------------------
// audio_frame_writer_if
//
// Bundles the audio_frame_writer signals other than clock and reset:
//   sample stream : in_valid, in_first, in_data           (into the writer)
//   RAM write     : audio_waddr, audio_wdata, audio_we     (out of the writer)
//   sequencer     : frame, seq_run (out), seq_done (in)
//   status        : busy, overrun, sync_err                (out of the writer)
//
// The master modport is the side that produces samples and owns the sequencer.
// The slave modport is the writer itself.
// ---------------------------------------------------------------------------
interface audio_frame_writer_if #(
    parameter int CHAN_W  = 3,
    parameter int FRAME_W = 4,
    parameter int AUDIO_W = CHAN_W + FRAME_W
);
    logic               in_valid;
    logic               in_first;
    logic [15:0]        in_data;
    logic [AUDIO_W-1:0] audio_waddr;
    logic [15:0]        audio_wdata;
    logic               audio_we;
    logic [FRAME_W-1:0] frame;
    logic               seq_run;
    logic               seq_done;
    logic               busy;
    logic               overrun;
    logic               sync_err;

    modport master (
        output in_valid, in_first, in_data, seq_done,
        input  audio_waddr, audio_wdata, audio_we, frame, seq_run,
               busy, overrun, sync_err
    );

    modport slave (
        input  in_valid, in_first, in_data, seq_done,
        output audio_waddr, audio_wdata, audio_we, frame, seq_run,
               busy, overrun, sync_err
    );
endinterface

// File: rtl/audio_frame_writer.sv
// ---------------------------------------------------------------------------
// audio_frame_writer
//
// Writer end of the circular audio sample buffer read by the DSP sequencer.
// Each channel-interleaved 16-bit sample goes to RAM address {chan, slot}.
// When a frame completes, its slot becomes pending. It is published on
// `frame` when the sequencer is released through seq_run.
// After every reset the whole RAM is zero-filled before samples are accepted.
//
// Ports:
//   ck   : clock, all logic on the rising edge
//   rst  : asynchronous active-low reset
//   bus  : audio_frame_writer_if.slave
//          in_valid/in_first/in_data   sample stream
//          audio_waddr/wdata/we        RAM write port
//          frame, seq_run, seq_done    sequencer handshake
//          busy, overrun, sync_err     status (overrun/sync_err sticky)
// ---------------------------------------------------------------------------
module audio_frame_writer #(
    parameter int CHAN_W  = 3,
    parameter int FRAME_W = 4,
    parameter int NCHAN   = 8,
    parameter int AUDIO_W = CHAN_W + FRAME_W
) (
    input logic                ck,
    input logic                rst,
    audio_frame_writer_if.slave bus
);

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam logic [AUDIO_W-1:0] CLR_LAST = '1;
    localparam logic [CHAN_W-1:0]  LAST_CH  = CHAN_W'(NCHAN - 1);

    state_t             state, state_n;
    logic [AUDIO_W-1:0] clr_cnt, clr_cnt_n;
    logic [FRAME_W-1:0] wslot, wslot_n;
    logic [CHAN_W-1:0]  ch_cnt, ch_cnt_n;
    logic               pending, pending_n;
    logic [FRAME_W-1:0] ready_slot, ready_slot_n;

    logic [AUDIO_W-1:0] waddr_q, waddr_n;
    logic [15:0]        wdata_q, wdata_n;
    logic               we_q, we_n;
    logic [FRAME_W-1:0] frame_q, frame_n;
    logic               seq_run_q, seq_run_n;
    logic               busy_q, busy_n;
    logic               overrun_q, overrun_n;
    logic               sync_err_q, sync_err_n;

    logic [CHAN_W-1:0]  eff_ch;
    logic               frame_done;
    logic               seq_start;

    // The write slot starts at the top of the ring and counts down.
    // The newest frame is therefore at `frame`, and older frames are at frame+k.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            state      <= CLEAR;
            clr_cnt    <= '0;
            wslot      <= '1;
            ch_cnt     <= '0;
            pending    <= 1'b0;
            ready_slot <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            frame_q    <= '0;
            seq_run_q  <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state      <= state_n;
            clr_cnt    <= clr_cnt_n;
            wslot      <= wslot_n;
            ch_cnt     <= ch_cnt_n;
            pending    <= pending_n;
            ready_slot <= ready_slot_n;
            waddr_q    <= waddr_n;
            wdata_q    <= wdata_n;
            we_q       <= we_n;
            frame_q    <= frame_n;
            seq_run_q  <= seq_run_n;
            busy_q     <= busy_n;
            overrun_q  <= overrun_n;
            sync_err_q <= sync_err_n;
        end
    end

    // The CLEAR state sweeps every RAM address once.
    // busy is registered with the clear writes, so it is high during exactly
    // the cycles in which a zero-fill write is presented.
    //
    // In RUN, the sequencer start looks at the pending flag and ready_slot
    // from before this edge. This means a frame that completes on the same
    // edge becomes pending behind the one being started, and it is not
    // counted as an overrun.
    always_comb begin
        state_n      = state;
        clr_cnt_n    = clr_cnt;
        wslot_n      = wslot;
        ch_cnt_n     = ch_cnt;
        pending_n    = pending;
        ready_slot_n = ready_slot;
        waddr_n      = waddr_q;
        wdata_n      = wdata_q;
        we_n         = 1'b0;
        frame_n      = frame_q;
        seq_run_n    = seq_run_q;
        busy_n       = 1'b0;
        overrun_n    = overrun_q;
        sync_err_n   = sync_err_q;
        eff_ch       = ch_cnt;
        frame_done   = 1'b0;
        seq_start    = 1'b0;

        case (state)
            CLEAR: begin
                we_n      = 1'b1;
                waddr_n   = clr_cnt;
                wdata_n   = '0;
                busy_n    = 1'b1;
                clr_cnt_n = clr_cnt + AUDIO_W'(1);
                if (clr_cnt == CLR_LAST) begin
                    state_n = RUN;
                end
            end

            RUN: begin
                seq_start = pending && !seq_run_q && !bus.seq_done;

                if (bus.in_valid) begin
                    // A channel-0 marker in the middle of a frame means
                    // synchronisation was lost. The frame restarts in the
                    // same slot, so the partial data is overwritten.
                    if (bus.in_first) begin
                        eff_ch = '0;
                        if (ch_cnt != '0) begin
                            sync_err_n = 1'b1;
                        end
                    end
                    we_n    = 1'b1;
                    waddr_n = AUDIO_W'({eff_ch, wslot});
                    wdata_n = bus.in_data;
                    if (eff_ch == LAST_CH) begin
                        frame_done   = 1'b1;
                        ch_cnt_n     = '0;
                        ready_slot_n = wslot;
                        wslot_n      = wslot - FRAME_W'(1);
                    end else begin
                        ch_cnt_n = eff_ch + CHAN_W'(1);
                    end
                end

                if (seq_start) begin
                    frame_n   = ready_slot;
                    seq_run_n = 1'b1;
                end else if (seq_run_q && bus.seq_done) begin
                    seq_run_n = 1'b0;
                end

                if (frame_done) begin
                    if (pending && !seq_start) begin
                        overrun_n = 1'b1;
                    end
                    pending_n = 1'b1;
                end else if (seq_start) begin
                    pending_n = 1'b0;
                end
            end

            default: begin
                state_n = CLEAR;
            end
        endcase
    end

    assign bus.audio_waddr = waddr_q;
    assign bus.audio_wdata = wdata_q;
    assign bus.audio_we    = we_q;
    assign bus.frame       = frame_q;
    assign bus.seq_run     = seq_run_q;
    assign bus.busy        = busy_q;
    assign bus.overrun     = overrun_q;
    assign bus.sync_err    = sync_err_q;

endmodule

// File: tb/tb_audio_frame_writer.sv
// ---------------------------------------------------------------------------
// tb_audio_frame_writer
//
// Directed sequence with random sample data and random gaps between samples.
// Every RUN cycle is compared against a behavioural model of the frame buffer.
// The model tracks the write slot, channel position, pending frame and
// sequencer state as plain integers.
// ---------------------------------------------------------------------------
module tb_audio_frame_writer;

    localparam int CHAN_W  = 3;
    localparam int FRAME_W = 4;
    localparam int NCHAN   = 8;
    localparam int AUDIO_W = CHAN_W + FRAME_W;
    localparam int DEPTH   = 1 << FRAME_W;
    localparam int ADDRS   = 1 << AUDIO_W;

    logic ck = 1'b0;
    logic rst = 1'b0;

    audio_frame_writer_if #(.CHAN_W(CHAN_W), .FRAME_W(FRAME_W), .AUDIO_W(AUDIO_W)) bus ();

    audio_frame_writer #(
        .CHAN_W(CHAN_W), .FRAME_W(FRAME_W), .NCHAN(NCHAN), .AUDIO_W(AUDIO_W)
    ) dut (
        .ck (ck),
        .rst(rst),
        .bus(bus)
    );

    always #5 ck = ~ck;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int m_wslot, m_ch, m_ready, m_frame, m_waddr, m_wdata;
    bit m_pending, m_run, m_over, m_sync, m_we;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        m_wslot = DEPTH - 1;
        m_ch = 0;
        m_ready = 0;
        m_frame = 0;
        m_pending = 0;
        m_run = 0;
        m_over = 0;
        m_sync = 0;
        m_we = 0;
        m_waddr = 0;
        m_wdata = 0;
    endtask

    // Advance the model by one RUN edge. It uses the inputs sampled at that edge.
    task automatic modelEdge(input bit v, input bit f, input int d, input bit done);
        bit start;
        bit complete;
        int ch;
        int done_slot;
        start = m_pending && !m_run && !done;
        complete = 0;
        done_slot = 0;
        m_we = v;
        if (v) begin
            ch = f ? 0 : m_ch;
            if (f && m_ch != 0) m_sync = 1;
            m_waddr = ch * DEPTH + m_wslot;
            m_wdata = d;
            if (ch == NCHAN - 1) begin
                complete = 1;
                done_slot = m_wslot;
                m_ch = 0;
                m_wslot = (m_wslot + DEPTH - 1) % DEPTH;
            end else begin
                m_ch = ch + 1;
            end
        end
        if (start) begin
            m_frame = m_ready;
            m_run = 1;
        end else if (m_run && done) begin
            m_run = 0;
        end
        if (complete) begin
            if (m_pending && !start) m_over = 1;
            m_pending = 1;
            m_ready = done_slot;
        end else if (start) begin
            m_pending = 0;
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".busy"}, 32'(bus.busy), 0);
        checkOutput({tag, ".we"}, 32'(bus.audio_we), 32'(m_we));
        if (m_we) begin
            checkOutput({tag, ".waddr"}, 32'(bus.audio_waddr), m_waddr);
            checkOutput({tag, ".wdata"}, 32'(bus.audio_wdata), m_wdata);
        end
        checkOutput({tag, ".frame"}, 32'(bus.frame), m_frame);
        checkOutput({tag, ".seq_run"}, 32'(bus.seq_run), 32'(m_run));
        checkOutput({tag, ".overrun"}, 32'(bus.overrun), 32'(m_over));
        checkOutput({tag, ".sync_err"}, 32'(bus.sync_err), 32'(m_sync));
    endtask

    task automatic checkZero(input string tag);
        checkOutput({tag, ".we"}, 32'(bus.audio_we), 0);
        checkOutput({tag, ".waddr"}, 32'(bus.audio_waddr), 0);
        checkOutput({tag, ".wdata"}, 32'(bus.audio_wdata), 0);
        checkOutput({tag, ".frame"}, 32'(bus.frame), 0);
        checkOutput({tag, ".seq_run"}, 32'(bus.seq_run), 0);
        checkOutput({tag, ".busy"}, 32'(bus.busy), 0);
        checkOutput({tag, ".overrun"}, 32'(bus.overrun), 0);
        checkOutput({tag, ".sync_err"}, 32'(bus.sync_err), 0);
    endtask

    // Drive one RUN cycle. The edge is taken, the model is advanced,
    // and the outputs are checked 1 time unit after the edge.
    task automatic applyStimulus(input bit v, input bit f, input logic [15:0] d,
                                 input bit done, input string tag);
        bus.in_valid = v;
        bus.in_first = f;
        bus.in_data  = d;
        bus.seq_done = done;
        @(posedge ck);
        modelEdge(v, f, int'(d), done);
        #1;
        checkAll(tag);
    endtask

    task automatic idle(input bit done, input string tag);
        applyStimulus(1'b0, 1'b0, 16'h0, done, tag);
    endtask

    task automatic feedFrame(input bit done, input string tag);
        for (int ch = 0; ch < NCHAN; ch++) begin
            repeat ($urandom_range(0, 2)) idle(done, tag);
            applyStimulus(1'b1, ch == 0, 16'($urandom_range(0, 65535)), done, tag);
        end
    endtask

    // Zero-fill sweep after reset release. Samples are offered throughout
    // the sweep and must be ignored.
    task automatic runClear(input string tag);
        for (int i = 0; i < ADDRS; i++) begin
            bus.in_valid = 1'b1;
            bus.in_first = 1'($urandom_range(0, 1));
            bus.in_data  = 16'($urandom_range(1, 65535));
            bus.seq_done = 1'b0;
            @(posedge ck);
            #1;
            checkOutput({tag, ".busy"}, 32'(bus.busy), 1);
            checkOutput({tag, ".we"}, 32'(bus.audio_we), 1);
            checkOutput({tag, ".waddr"}, 32'(bus.audio_waddr), i);
            checkOutput({tag, ".wdata"}, 32'(bus.audio_wdata), 0);
            checkOutput({tag, ".seq_run"}, 32'(bus.seq_run), 0);
        end
        modelReset();
    endtask

    initial begin
        bus.in_valid = 1'b1;
        bus.in_first = 1'b0;
        bus.in_data  = 16'h0;
        bus.seq_done = 1'b0;
        rst = 1'b0;
        modelReset();

        // Reset state
        #12;
        checkZero("reset");

        // Clear sweep, then the first RUN edge
        @(negedge ck);
        rst = 1'b1;
        runClear("clear");
        idle(1'b0, "clear_exit");

        // Single frame into slot 15
        for (int ch = 0; ch < NCHAN; ch++) begin
            applyStimulus(1'b1, ch == 0, 16'(16'h1000 + ch), 1'b0, "single");
            checkOutput("single.addr", 32'(bus.audio_waddr), ch * DEPTH + 15);
            checkOutput("single.data", 32'(bus.audio_wdata), 32'h1000 + ch);
        end
        idle(1'b0, "single_start");
        checkOutput("single.frame", 32'(bus.frame), 15);
        checkOutput("single.run", 32'(bus.seq_run), 1);

        // Handshake: long run, stop, pending frame waits for done to drop
        repeat (20) idle(1'b0, "hs_hold");
        checkOutput("hs.run_held", 32'(bus.seq_run), 1);
        idle(1'b1, "hs_done");
        checkOutput("hs.run_fall", 32'(bus.seq_run), 0);
        feedFrame(1'b1, "hs_feed");
        repeat (3) idle(1'b1, "hs_wait");
        checkOutput("hs.no_restart", 32'(bus.seq_run), 0);
        idle(1'b0, "hs_restart");
        checkOutput("hs.restart_run", 32'(bus.seq_run), 1);
        checkOutput("hs.restart_frame", 32'(bus.frame), 14);
        idle(1'b1, "hs_stop");
        idle(1'b0, "hs_quiet");

        // Overrun: slots 13, 12, 11 with done stuck low
        repeat (3) feedFrame(1'b0, "ovr_feed");
        idle(1'b0, "ovr_idle");
        checkOutput("ovr.flag", 32'(bus.overrun), 1);
        checkOutput("ovr.frame_first", 32'(bus.frame), 13);
        idle(1'b1, "ovr_done");
        idle(1'b0, "ovr_undone");
        checkOutput("ovr.frame_newest", 32'(bus.frame), 11);
        idle(1'b1, "ovr_stop");
        idle(1'b0, "ovr_quiet");

        // Resync: channel-0 marker on the 4th sample, slot 10
        for (int s = 0; s < 3; s++)
            applyStimulus(1'b1, s == 0, 16'($urandom_range(0, 65535)), 1'b0, "rs_pre");
        applyStimulus(1'b1, 1'b1, 16'h5a5a, 1'b0, "rs_mark");
        checkOutput("rs.sync_err", 32'(bus.sync_err), 1);
        checkOutput("rs.addr", 32'(bus.audio_waddr), 10);
        for (int s = 0; s < NCHAN - 1; s++)
            applyStimulus(1'b1, 1'b0, 16'($urandom_range(0, 65535)), 1'b0, "rs_post");
        idle(1'b0, "rs_start");
        checkOutput("rs.frame", 32'(bus.frame), 10);
        idle(1'b1, "rs_stop");
        idle(1'b0, "rs_quiet");

        // Wrap: 17 frames with immediate done
        for (int n = 0; n < 17; n++) begin
            feedFrame(1'b0, "wrap_feed");
            idle(1'b0, "wrap_start");
            idle(1'b1, "wrap_done");
            idle(1'b0, "wrap_undone");
        end

        // Reset mid-frame while the sequencer is running
        feedFrame(1'b0, "mr_feed");
        idle(1'b0, "mr_start");
        checkOutput("mr.run_before", 32'(bus.seq_run), 1);
        for (int s = 0; s < 3; s++)
            applyStimulus(1'b1, s == 0, 16'($urandom_range(0, 65535)), 1'b0, "mr_part");
        #2;
        rst = 1'b0;
        #1;
        checkZero("mid_reset");
        @(negedge ck);
        rst = 1'b1;
        runClear("reclear");
        idle(1'b0, "reclear_exit");
        feedFrame(1'b0, "after_feed");
        idle(1'b0, "after_start");
        checkOutput("after.frame", 32'(bus.frame), 15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/audio_frame_writer.md
# audio_frame_writer

Writer end of the audio sample buffer that the DSP sequencer reads. Accepts a channel-interleaved 16-bit sample stream and writes each sample into the circular audio RAM at `{chan, slot}`. When a frame is complete it publishes the slot as `frame` and runs the sequencer through its run/done handshake. After reset it first zero-fills the whole buffer.

## Interface
- `CHAN_W`, 3, channel address bits.
- `FRAME_W`, 4, frame slot bits; ring depth is 2^FRAME_W.
- `NCHAN`, 8, channels per frame (1..2^CHAN_W).
- `AUDIO_W`, CHAN_W+FRAME_W, audio RAM address width.

Ports:
- `ck` in 1: the single clock; all logic on posedge.
- `rst` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: sample strobe; one sample per cycle max.
- `in_first` in 1: qualifies `in_valid`; the sample is channel 0 (resync marker).
- `in_data` in 16: sample value.
- `audio_waddr` out AUDIO_W: RAM write address, `{chan, slot}`, with chan in the MSBs.
- `audio_wdata` out 16: RAM write data.
- `audio_we` out 1: RAM write enable.
- `frame` out FRAME_W: newest complete slot; sequencer reads at `frame+offset`.
- `seq_run` out 1: drives the sequencer's active-low reset (1 = run).
- `seq_done` in 1: sequencer halted.
- `busy` out 1: clear in progress.
- `overrun` out 1: sticky; a completed frame was dropped.
- `sync_err` out 1: sticky; `in_first` arrived mid-frame.

## Operation
- Reset (`rst`=0, async) forces the following:
  - All outputs go to 0.
  - `wslot` = 2^FRAME_W−1, `ch_cnt` = 0, `pending` = 0, `ready_slot` = 0.
  - State = CLEAR.
- CLEAR:
  - Counter runs 0..2^AUDIO_W−1 with `audio_we`=1, `audio_wdata`=0, `audio_waddr`=counter, one address per cycle.
  - `busy`=1 and `in_valid` is ignored.
  - After the last address, state goes to RUN and `busy`=0.
- RUN, on each `in_valid`:
  - If `in_first` && `ch_cnt`≠0: set `sync_err`, treat `ch_cnt` as 0, restart the frame in the same `wslot`.
  - Write `{ch_cnt, wslot}` ← `in_data`, then increment `ch_cnt`.
  - Samples with `in_first`=0 at `ch_cnt`=0 are accepted normally.
- Frame complete (write of channel NCHAN−1):
  - `ch_cnt`←0, `ready_slot`←`wslot`, `wslot`←`wslot`−1 (mod 2^FRAME_W, 0 wraps to 2^FRAME_W−1).
  - `pending`←1. If `pending` was already 1 and is not consumed that cycle, set `overrun`; `ready_slot` always takes the newest slot.
- Sequencer start:
  - Condition: `pending` && !`seq_run` && !`seq_done`.
  - Action: `frame`←`ready_slot`, `seq_run`←1, `pending`←0.
  - If a frame completes on the same edge, the start uses the old `ready_slot`, the new frame becomes pending, and no overrun is flagged.
- Sequencer stop: `seq_run`=1 && `seq_done`=1 → `seq_run`←0. No restart until `seq_done` has returned to 0.
- `frame` changes only when `seq_run`=0, so it is stable for the whole sequencer run.
- Offset 0 is the newest frame and offset k is k frames older. Offsets are legal up to 2^FRAME_W−2 (slot `frame`+2^FRAME_W−1 is the slot currently being written).

## Timing
- `in_valid` sampled at edge k → `audio_we`/`audio_waddr`/`audio_wdata` valid during cycle k+1, for exactly one cycle. No backpressure.
- Last sample of a frame at edge k → `pending`=1 after edge k → `frame` update and `seq_run` rise at edge k+1, provided the start condition holds.
- `seq_done`=1 sampled at edge m → `seq_run`=0 after edge m. Earliest restart is the first edge with `seq_done`=0 and `pending`=1.
- CLEAR lasts exactly 2^AUDIO_W cycles after `rst` deasserts (128 with defaults). The first `in_valid` is accepted on the first RUN edge.
- Reset asserted mid-frame or mid-run: `seq_run` drops immediately (asynchronously), the partial frame is lost, and CLEAR reruns.

## Test plan
- **Clear:** release `rst` with `in_valid` held 1 → `busy`=1 for 128 cycles; writes to addresses 0..127 with data 0; no sample writes during clear; `busy`=0 afterwards.
- **Single frame:** 8 samples `0x1000+ch` → writes to addresses ch·16+15; 2 edges after the last sample, `frame`=15 and `seq_run`=1.
- **Handshake:** hold `seq_done`=0 for 20 cycles, then 1 → `seq_run` falls at the next edge. A pending frame starts only after `seq_done` returns to 0.
- **Overrun:** `seq_done` stuck at 0 with 3 frames fed → frame 1 runs (`frame`=15), frame 3 completes while frame 2 is pending so `overrun`=1; after done/undone, `frame`=13.
- **Resync:** `in_first` with the 4th sample → `sync_err`=1 and that sample is written to address {0,15}; the frame then completes after 7 more samples.
- **Wrap and reset:** 17 frames with immediate done → `frame` sequence 15,14,…,0,15. Assert `rst` mid-frame → outputs are 0 at once and CLEAR restarts.
